mem_ctrl: RTL and testbench

Two-port controller that shares the 512 x 32-bit single-port data `ram` between the RV32I instruction-fetch path (read-only port I) and the load/store path (read/write port D). Arbitrates round-robin and converts byte-strobed stores (`sb`/`sh`) into read-modify-write sequences, because the RAM only writes full words. Sits between the core and `ram` and is the only driver of the RAM's `addr`, `din` and `write_en`.

---
 rtl/mem_ctrl_if.sv | 33 +++
 rtl/mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Core-side and RAM-side signal bundle for mem_ctrl.
// slave = controller view, master = core + RAM environment view.
interface mem_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_ack;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_ack;
    logic [31:0]       d_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_we;
    logic [31:0]       ram_dout;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, ram_dout,
        output i_ack, i_rdata, d_ack, d_rdata, ram_addr, ram_din, ram_we
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, ram_dout,
        input  i_ack, i_rdata, d_ack, d_rdata, ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/mem_ctrl.sv
// Shares one single-port word RAM between instruction fetch (I) and load/store (D):
// round-robin arbitration, byte-strobed stores done as read-modify-write.
module mem_ctrl_lane (
    input  logic       strb,
    input  logic [7:0] wbyte,
    input  logic [7:0] rbyte,
    output logic [7:0] mbyte
);
    assign mbyte = strb ? wbyte : rbyte;
endmodule

module mem_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_ctrl_if.slave bus
);
    localparam int NUM_LANES = 4;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_ACK} state_e;

    typedef struct packed {
        logic              port_d;
        logic              we;
        logic [ADDR_W-1:0] idx;
        logic [31:0]       wdata;
        logic [NUM_LANES-1:0] wstrb;
    } txn_t;

    state_e            state, state_nxt;
    txn_t              txn, txn_nxt;
    logic              last_d, last_nxt;
    logic              pick_d;
    logic [31:0]       rdata, rdata_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [31:0]       din_q, din_nxt;
    logic              we_q, we_nxt;
    logic              iack_q, iack_nxt;
    logic              dack_q, dack_nxt;
    logic [31:0]       merged;

    // Merge operates on the word being captured, so WR can follow CAP directly.
    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            mem_ctrl_lane u_lane (
                .strb  (txn.wstrb[g]),
                .wbyte (txn.wdata[8*g +: 8]),
                .rbyte (bus.ram_dout[8*g +: 8]),
                .mbyte (merged[8*g +: 8])
            );
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        txn_nxt   = txn;
        last_nxt  = last_d;
        rdata_nxt = rdata;
        addr_nxt  = addr_q;
        din_nxt   = din_q;
        we_nxt    = 1'b0;
        iack_nxt  = 1'b0;
        dack_nxt  = 1'b0;
        pick_d    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    pick_d        = bus.d_req && (!bus.i_req || !last_d);
                    last_nxt      = pick_d;
                    txn_nxt.port_d = pick_d;
                    txn_nxt.we    = pick_d && bus.d_we;
                    txn_nxt.idx   = pick_d ? bus.d_addr[ADDR_W+1:2] : bus.i_addr[ADDR_W+1:2];
                    txn_nxt.wdata = bus.d_wdata;
                    txn_nxt.wstrb = bus.d_wstrb;
                    addr_nxt      = txn_nxt.idx;
                    if (txn_nxt.we && (bus.d_wstrb == 4'hF)) begin
                        state_nxt = S_WR;
                        we_nxt    = 1'b1;
                        din_nxt   = bus.d_wdata;
                    end else if (txn_nxt.we && (bus.d_wstrb == 4'h0)) begin
                        state_nxt = S_ACK;
                        dack_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_RD;
                    end
                end
            end
            S_RD:  state_nxt = S_CAP;
            S_CAP: begin
                rdata_nxt = bus.ram_dout;
                if (txn.we) begin
                    state_nxt = S_WR;
                    we_nxt    = 1'b1;
                    din_nxt   = merged;
                end else begin
                    state_nxt = S_ACK;
                    iack_nxt  = !txn.port_d;
                    dack_nxt  = txn.port_d;
                end
            end
            S_WR: begin
                state_nxt = S_ACK;
                dack_nxt  = 1'b1;
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            txn    <= '0;
            last_d <= 1'b1;
            rdata  <= '0;
            addr_q <= '0;
            din_q  <= '0;
            we_q   <= 1'b0;
            iack_q <= 1'b0;
            dack_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            txn    <= txn_nxt;
            last_d <= last_nxt;
            rdata  <= rdata_nxt;
            addr_q <= addr_nxt;
            din_q  <= din_nxt;
            we_q   <= we_nxt;
            iack_q <= iack_nxt;
            dack_q <= dack_nxt;
        end
    end

    assign bus.i_ack    = iack_q;
    assign bus.d_ack    = dack_q;
    assign bus.i_rdata  = rdata;
    assign bus.d_rdata  = rdata;
    assign bus.ram_addr = addr_q;
    assign bus.ram_din  = din_q;
    assign bus.ram_we   = we_q;

    logic unused_bits;
    assign unused_bits = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                           bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: registered-read RAM, transaction-level reference model checked
// every cycle, directed literal scenarios plus randomized concurrent I/D traffic.
module tb_mem_ctrl;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
    mem_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // RAM with registered read
    logic [31:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= ram_mem[bus.ram_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // write monitor for directed literal checks
    int          we_cnt = 0;
    logic [31:0] we_addr = '0;
    logic [31:0] we_din = '0;
    always @(negedge clk)
        if (rst_n && bus.ram_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= 32'(bus.ram_addr);
            we_din  <= bus.ram_din;
        end

    // Reference model: one transaction at a time, outcome fixed at grant time
    logic [31:0]       shadow [DEPTH];
    bit                m_busy = 0, m_port_d = 0, m_last_d = 1;
    int                m_ack_cyc, m_we_cyc, m_rd_cyc, m_free = 0;
    logic [ADDR_W-1:0] m_idx;
    logic [31:0]       m_din, m_rdata = '0, a_t, old_t;
    logic [3:0]        s_t;
    bit                exp_i, exp_d, exp_we;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ctl", {29'b0, bus.i_ack, bus.d_ack, bus.ram_we}, 32'h0);
            chk("rst_addr", 32'(bus.ram_addr), 32'h0);
            chk("rst_din", bus.ram_din, 32'h0);
            chk("rst_rdata", bus.d_rdata, 32'h0);
            m_busy = 0; m_last_d = 1; m_rdata = '0; m_free = 0;
        end else begin
            exp_i  = m_busy && (cyc == m_ack_cyc) && !m_port_d;
            exp_d  = m_busy && (cyc == m_ack_cyc) && m_port_d;
            exp_we = m_busy && (cyc == m_we_cyc);
            chk("acks", {30'b0, bus.i_ack, bus.d_ack}, {30'b0, exp_i, exp_d});
            chk("ram_we", {31'b0, bus.ram_we}, {31'b0, exp_we});
            if (exp_we) begin
                chk("we_addr", 32'(bus.ram_addr), 32'(m_idx));
                chk("we_din", bus.ram_din, m_din);
            end
            if (m_busy && (cyc == m_rd_cyc || cyc == m_rd_cyc + 1))
                chk("rd_addr", 32'(bus.ram_addr), 32'(m_idx));
            if (exp_i) chk("i_rdata", bus.i_rdata, m_rdata);
            if (exp_d) chk("d_rdata", bus.d_rdata, m_rdata);
            if (exp_i || exp_d) begin
                m_busy = 0;
                m_free = cyc + 1;
            end
            if (!m_busy && cyc >= m_free && (bus.i_req || bus.d_req)) begin
                m_port_d = bus.d_req && (!bus.i_req || !m_last_d);
                m_last_d = m_port_d;
                a_t      = m_port_d ? bus.d_addr : bus.i_addr;
                m_idx    = a_t[ADDR_W+1:2];
                old_t    = shadow[m_idx];
                m_busy   = 1;
                m_we_cyc = -10;
                m_rd_cyc = -10;
                if (m_port_d && bus.d_we) begin
                    s_t = bus.d_wstrb;
                    if (s_t == 4'h0) begin
                        m_ack_cyc = cyc + 1;
                    end else if (s_t == 4'hF) begin
                        m_din = bus.d_wdata;
                        m_we_cyc = cyc + 1;
                        m_ack_cyc = cyc + 2;
                        shadow[m_idx] = m_din;
                    end else begin
                        for (int k = 0; k < 4; k++)
                            m_din[8*k +: 8] = s_t[k] ? bus.d_wdata[8*k +: 8] : old_t[8*k +: 8];
                        m_rd_cyc = cyc + 1;
                        m_we_cyc = cyc + 3;
                        m_ack_cyc = cyc + 4;
                        m_rdata = old_t;
                        shadow[m_idx] = m_din;
                    end
                end else begin
                    m_rd_cyc = cyc + 1;
                    m_ack_cyc = cyc + 3;
                    m_rdata = old_t;
                end
            end
        end
    end

    task automatic d_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s, output int lat, output logic [31:0] rd);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_wstrb = s;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!bus.d_ack && lat < 40);
        chk("d_ack_seen", {31'b0, bus.d_ack}, 32'h1);
        rd = bus.d_rdata;
        bus.d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic i_txn(input logic [31:0] a, output int lat, output logic [31:0] rd);
        bus.i_req = 1'b1; bus.i_addr = a;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!bus.i_ack && lat < 40);
        chk("i_ack_seen", {31'b0, bus.i_ack}, 32'h1);
        rd = bus.i_rdata;
        bus.i_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
    endtask

    int          lat, cnt0, nack, wt;
    logic [31:0] rd;
    int          ord [4];
    bit          both;

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            ram_mem[k] = 32'hA500_0000 | k;
            shadow[k]  = 32'hA500_0000 | k;
        end
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
        repeat (3) begin @(posedge clk); #1; end
        chk("reset_acks", {30'b0, bus.i_ack, bus.d_ack}, 32'h0);
        chk("reset_we", {31'b0, bus.ram_we}, 32'h0);
        chk("reset_rdata", bus.i_rdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // full store then load of the top word
        d_txn(1, 32'h7FC, 32'h0, 4'hF, lat, rd);
        chk("full_lat", lat, 2);
        chk("full_we_addr", we_addr, 32'd511);
        chk("full_we_din", we_din, 32'h0);
        d_txn(0, 32'h7FC, 32'h0, 4'h0, lat, rd);
        chk("load_lat", lat, 3);
        chk("load_data", rd, 32'h0);

        // partial store read-modify-write
        d_txn(1, 32'h7F8, 32'h1122_3344, 4'hF, lat, rd);
        d_txn(1, 32'h7F8, 32'hAABB_CCDD, 4'b0100, lat, rd);
        chk("part_lat", lat, 4);
        chk("part_we_din", we_din, 32'h11BB_3344);
        chk("part_rdata_premerge", rd, 32'h1122_3344);
        i_txn(32'h7F8, lat, rd);
        chk("fetch_lat", lat, 3);
        chk("fetch_data", rd, 32'h11BB_3344);

        // zero-strobe store
        d_txn(1, 32'h7F4, 32'h5566_7788, 4'hF, lat, rd);
        cnt0 = we_cnt;
        d_txn(1, 32'h7F4, 32'hFFFF_FFFF, 4'h0, lat, rd);
        chk("zero_lat", lat, 1);
        chk("zero_no_we", we_cnt, cnt0);
        d_txn(0, 32'h7F4, 32'h0, 4'h0, lat, rd);
        chk("zero_readback", rd, 32'h5566_7788);

        // address aliasing
        d_txn(1, 32'h000, 32'hDEAD_BEEF, 4'hF, lat, rd);
        d_txn(0, 32'h800, 32'h0, 4'h0, lat, rd);
        chk("alias_data", rd, 32'hDEAD_BEEF);

        // both requests held after reset: I, D, I, D
        reset_pulse();
        bus.i_req = 1; bus.i_addr = 32'h10;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h20;
        nack = 0; both = 0; wt = 0;
        while (nack < 4 && wt < 60) begin
            @(posedge clk); #1; wt++;
            if (bus.i_ack && bus.d_ack) both = 1;
            if (bus.i_ack) begin ord[nack] = 0; nack++; end
            else if (bus.d_ack) begin ord[nack] = 1; nack++; end
        end
        bus.i_req = 0; bus.d_req = 0;
        chk("rr_count", nack, 4);
        chk("rr_no_coincide", {31'b0, both}, 32'h0);
        for (int k = 0; k < nack; k++) chk($sformatf("rr_order%0d", k), ord[k], k % 2);
        repeat (2) begin @(posedge clk); #1; end

        // randomized concurrent traffic, words 0..31 with aliasing
        fork
            begin
                for (int n = 0; n < 80; n++) begin
                    int w;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    bus.i_addr = ($urandom_range(0, 1) << 11) | ($urandom_range(0, 31) << 2)
                                 | $urandom_range(0, 3);
                    bus.i_req = 1; w = 0;
                    do begin @(posedge clk); #1; w++; end while (!bus.i_ack && w < 60);
                    chk("rand_i_ack", {31'b0, bus.i_ack}, 32'h1);
                    bus.i_req = 0;
                end
            end
            begin
                for (int n = 0; n < 80; n++) begin
                    int w, r;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    r = $urandom_range(0, 5);
                    bus.d_we = 1'($urandom_range(0, 1));
                    bus.d_addr = ($urandom_range(0, 1) << 11) | ($urandom_range(0, 31) << 2)
                                 | $urandom_range(0, 3);
                    bus.d_wdata = $urandom;
                    bus.d_wstrb = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom_range(0, 15));
                    bus.d_req = 1; w = 0;
                    do begin @(posedge clk); #1; w++; end while (!bus.d_ack && w < 60);
                    chk("rand_d_ack", {31'b0, bus.d_ack}, 32'h1);
                    bus.d_req = 0;
                end
            end
        join
        repeat (2) begin @(posedge clk); #1; end

        // reset in the middle of a partial store's WR cycle
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h190;
        bus.d_wdata = 32'h0000_7700; bus.d_wstrb = 4'b0010;
        wt = 0;
        do begin @(posedge clk); #1; wt++; end while (!bus.ram_we && wt < 10);
        chk("mid_we_seen", {31'b0, bus.ram_we}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_we_low", {31'b0, bus.ram_we}, 32'h0);
        chk("mid_acks_low", {30'b0, bus.i_ack, bus.d_ack}, 32'h0);
        chk("mid_addr_low", 32'(bus.ram_addr), 32'h0);
        chk("mid_din_low", bus.ram_din, 32'h0);
        bus.d_req = 0;
        repeat (2) begin @(posedge clk); #1; end
        bus.i_req = 1; bus.i_addr = 32'hA0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'hA4;
        rst_n = 1'b1;
        wt = 0;
        do begin @(posedge clk); #1; wt++; end while (!bus.i_ack && !bus.d_ack && wt < 20);
        chk("post_first_i", {30'b0, bus.i_ack, bus.d_ack}, 32'h2);
        chk("post_i_data", bus.i_rdata, 32'hA500_0028);
        bus.i_req = 0;
        wt = 0;
        do begin @(posedge clk); #1; wt++; end while (!bus.d_ack && wt < 20);
        chk("post_d_data", bus.d_rdata, 32'hA500_0029);
        bus.d_req = 0;
        repeat (3) begin @(posedge clk); #1; end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
